aes_sub_bytes_iter: RTL and testbench

Iterative, parametrised AES SubBytes engine. It accepts a full AES state word over a valid/ready handshake and substitutes `SBOX_PAR` bytes per cycle through shared S-box lookups until every byte is done. It then holds the result until the consumer takes it. It sits between the round controller and ShiftRows, and trades S-box area for latency through `SBOX_PAR`. It also supports an inverse (decrypt) mode.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_sbox_lut.sv | 20 ++
 rtl/aes_sub_bytes_iter.sv | 126 ++++++++++++
 tb/tb_aes_sub_bytes_iter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 forward/inverse S-box tables and the
// SubBytes engine FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lut.sv
// Combinational single-byte AES S-box lookup. The inverse table is only
// selectable when AES_SUB_BYTES_INV_EN is defined.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

`ifdef AES_SUB_BYTES_INV_EN
  assign byte_out = inv ? SBOX_INV[byte_in] : SBOX_FWD[byte_in];
`else
  logic w_unused_inv;

  assign w_unused_inv = inv;
  assign byte_out     = SBOX_FWD[byte_in];
`endif

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes engine: SBOX_PAR shared lookups per cycle over a
// STATE_BYTES word. Inverse mode is enabled by AES_SUB_BYTES_INV_EN.
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int STATE_BYTES = 16,
  parameter int SBOX_PAR    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*STATE_BYTES-1:0] in_data,
  input  logic                     in_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*STATE_BYTES-1:0] out_data
);

  if (STATE_BYTES < 1 || SBOX_PAR < 1 || (STATE_BYTES % SBOX_PAR) != 0) begin : g_bad_param
    $error("aes_sub_bytes_iter: SBOX_PAR must be >=1 and divide STATE_BYTES");
  end

  localparam int NCHUNK = STATE_BYTES / SBOX_PAR;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t                   r_state;
  state_t                   w_next;
  logic [CW-1:0]            r_cnt;
  logic                     r_inv;
  logic [8*STATE_BYTES-1:0] r_work;
  logic                     w_accept;
  logic                     w_last;
  logic [7:0]               w_lut_in  [SBOX_PAR];
  logic [7:0]               w_lut_out [SBOX_PAR];

  assign w_last   = (r_cnt == CW'(NCHUNK - 1));
  assign out_data = r_work;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: if (w_last) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef AES_SUB_BYTES_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_inv <= 1'b0;
    else if (w_accept) r_inv <= in_inv;
  end
`else
  logic w_unused_inv;

  assign w_unused_inv = in_inv;
  assign r_inv        = 1'b0;
`endif

  // Chunk mux: route the bytes of the current chunk to the shared lookups.
  always_comb begin
    for (int j = 0; j < SBOX_PAR; j++) begin
      w_lut_in[j] = '0;
      for (int c = 0; c < NCHUNK; c++) begin
        if (r_cnt == CW'(c)) w_lut_in[j] = r_work[(c*SBOX_PAR + j)*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < SBOX_PAR; g++) begin : g_lut
    aes_sbox_lut u_lut (
      .byte_in  (w_lut_in[g]),
      .inv      (r_inv),
      .byte_out (w_lut_out[g])
    );
  end

  // NOTE: the working register is reset because it drives out_data, which
  // must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_work <= in_data;
          r_cnt  <= '0;
        end
        BUSY: begin
          for (int c = 0; c < NCHUNK; c++) begin
            for (int j = 0; j < SBOX_PAR; j++) begin
              if (r_cnt == CW'(c)) r_work[(c*SBOX_PAR + j)*8 +: 8] <= w_lut_out[j];
            end
          end
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Self-checking bench for aes_sub_bytes_iter: default, SBOX_PAR sweep and a
// 4-byte instance against a GF(2^8)-derived S-box reference model.
module tb_aes_sub_bytes_iter;

`ifdef AES_SUB_BYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // default instance
  logic         in_valid, in_inv, out_ready;
  logic [127:0] in_data;
  logic         in_ready, out_valid;
  logic [127:0] out_data;

  aes_sub_bytes_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  // sweep instances share their inputs
  logic         sw_valid, sw_inv, sw_out_ready;
  logic [127:0] sw_data;
  logic         p1_in_ready, p1_out_valid, p16_in_ready, p16_out_valid;
  logic [127:0] p1_out_data, p16_out_data;

  aes_sub_bytes_iter #(.STATE_BYTES(16), .SBOX_PAR(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(p1_in_ready),
    .in_data(sw_data), .in_inv(sw_inv), .out_valid(p1_out_valid),
    .out_ready(sw_out_ready), .out_data(p1_out_data)
  );

  aes_sub_bytes_iter #(.STATE_BYTES(16), .SBOX_PAR(16)) dut_p16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(p16_in_ready),
    .in_data(sw_data), .in_inv(sw_inv), .out_valid(p16_out_valid),
    .out_ready(sw_out_ready), .out_data(p16_out_data)
  );

  // small 4-byte instance
  logic        sm_valid, sm_inv, sm_out_ready;
  logic [31:0] sm_data;
  logic        sm_in_ready, sm_out_valid;
  logic [31:0] sm_out_data;

  aes_sub_bytes_iter #(.STATE_BYTES(4), .SBOX_PAR(2)) dut_sm (
    .clk(clk), .rst_n(rst_n), .in_valid(sm_valid), .in_ready(sm_in_ready),
    .in_data(sm_data), .in_inv(sm_inv), .out_valid(sm_out_valid),
    .out_ready(sm_out_ready), .out_data(sm_out_data)
  );

  // ---------------- reference model ----------------
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  task automatic build_ref();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = ginv(8'(x));
      fwd_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                     ^ {b[3:0], b[7:4]} ^ 8'h63;
      inv_tab[fwd_tab[x]] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_word(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = (inv && INV_EN) ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- default-instance drivers ----------------
  task automatic send_word(input logic [127:0] d, input logic inv);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    in_inv   = 1'($urandom);
  endtask

  task automatic wait_out(output int lat, output logic [127:0] d);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    d = out_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b out_data=%h, required 0 0 0",
               in_ready, out_valid, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_forward_vector();
    logic [127:0] d;
    int           lat;
    out_ready = 1'b1;
    send_word(128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
    wait_out(lat, d);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL fwd_latency: got %0d, required 4", lat);
    end
    checks++;
    if (d !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
      failures++;
      $display("FAIL fwd_data: got %h, required %h", d, 128'h76abd7fe2b670130c56f6bf27b777c63);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fwd_one_cycle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_inverse();
    logic [127:0] d, exp;
    int           lat;
    exp = INV_EN ? 128'h0 : {16{8'hfb}};
    out_ready = 1'b1;
    send_word({16{8'h63}}, 1'b1);
    wait_out(lat, d);
    checks++;
    if (d !== exp || lat != 4) begin
      failures++;
      $display("FAIL inverse: got %h lat %0d, required %h lat 4", d, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] d, held, nd;
    int           lat;
    out_ready = 1'b0;
    send_word({8{16'hff53}}, 1'b0);
    wait_out(lat, d);
    checks++;
    if (d !== {8{16'h16ed}}) begin
      failures++;
      $display("FAIL bp_data: got %h, required %h", d, {8{16'h16ed}});
    end
    held     = d;
    in_valid = 1'b1;
    in_data  = rand128();
    in_inv   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_data=%h, required 1 0 %h",
                 i, out_valid, in_ready, out_data, held);
      end
    end
    nd        = rand128();
    in_data   = nd;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    wait_out(lat, d);
    checks++;
    if (lat != 4 || d !== ref_word(nd, 1'b0)) begin
      failures++;
      $display("FAIL bp_next_word: got %h lat %0d, required %h lat 4", d, lat, ref_word(nd, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0] w, d;
    logic         inv;
    int           lat;
    for (int i = 0; i < 200; i++) begin
      w         = rand128();
      inv       = 1'($urandom);
      out_ready = 1'b0;
      send_word(w, inv);
      wait_out(lat, d);
      checks++;
      if (lat != 4 || d !== ref_word(w, inv)) begin
        failures++;
        $display("FAIL rand[%0d]: got %h lat %0d, required %h lat 4", i, d, lat, ref_word(w, inv));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_release[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] w, d;
    int           lat;
    out_ready = 1'b1;
    send_word('0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: out_valid=%b in_ready=%b out_data=%h, required 0 0 0",
               out_valid, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_release: in_ready=%b, required 1", in_ready);
    end
    w = rand128();
    send_word(w, 1'b0);
    wait_out(lat, d);
    checks++;
    if (lat != 4 || d !== ref_word(w, 1'b0)) begin
      failures++;
      $display("FAIL reset_next_word: got %h lat %0d, required %h lat 4", d, lat, ref_word(w, 1'b0));
    end
    @(negedge clk);
    out_ready = 1'b0;
    send_word(rand128(), 1'b0);
    wait_out(lat, d);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_done: out_valid=%b out_data=%h, required 0 0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [127:0] w, d1, d16;
    logic         inv;
    int           n, lat1, lat16;
    sw_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (!(p1_in_ready && p16_in_ready) && n < 50) begin
        @(negedge clk);
        n++;
      end
      w        = rand128();
      inv      = 1'($urandom);
      sw_valid = 1'b1;
      sw_data  = w;
      sw_inv   = inv;
      @(negedge clk);
      sw_valid = 1'b0;
      sw_data  = rand128();
      sw_inv   = ~inv;
      lat1 = -1; lat16 = -1; d1 = '0; d16 = '0;
      for (int c = 1; c <= 40 && (lat1 < 0 || lat16 < 0); c++) begin
        @(negedge clk);
        if (p16_out_valid && lat16 < 0) begin lat16 = c; d16 = p16_out_data; end
        if (p1_out_valid && lat1 < 0)   begin lat1 = c;  d1 = p1_out_data;   end
      end
      @(negedge clk);
      checks++;
      if (lat16 != 1 || d16 !== ref_word(w, inv)) begin
        failures++;
        $display("FAIL sweep_par16[%0d]: got %h lat %0d, required %h lat 1", i, d16, lat16, ref_word(w, inv));
      end
      checks++;
      if (lat1 != 16 || d1 !== ref_word(w, inv)) begin
        failures++;
        $display("FAIL sweep_par1[%0d]: got %h lat %0d, required %h lat 16", i, d1, lat1, ref_word(w, inv));
      end
    end
  endtask

  task automatic test_small();
    logic [31:0] w, d, exp;
    int          n, lat;
    sm_out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      w = (i == 0) ? 32'h00112233 : $urandom;
      for (int b = 0; b < 4; b++) exp[8*b +: 8] = fwd_tab[w[8*b +: 8]];
      n = 0;
      while (!sm_in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      sm_valid = 1'b1;
      sm_data  = w;
      sm_inv   = 1'b0;
      @(negedge clk);
      sm_valid = 1'b0;
      sm_data  = $urandom;
      lat = 0;
      while (!sm_out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      d = sm_out_data;
      checks++;
      if (i == 0 && d !== 32'h638293c3) begin
        failures++;
        $display("FAIL small_vector: got %h, required 638293c3", d);
      end else if (lat != 2 || d !== exp) begin
        failures++;
        $display("FAIL small[%0d]: got %h lat %0d, required %h lat 2", i, d, lat, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
    sw_valid = 1'b0; sw_inv = 1'b0; sw_out_ready = 1'b0; sw_data = '0;
    sm_valid = 1'b0; sm_inv = 1'b0; sm_out_ready = 1'b0; sm_data = '0;
    build_ref();
    test_reset();
    test_forward_vector();
    test_inverse();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_sweep();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
